// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling FSM and a
// one-entry valid/ready output buffer with frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned F    = 50000000,
    parameter int unsigned BAUD = 115200,
    parameter int unsigned N    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    output logic [N-1:0] data,
    output logic         valid,
    input  logic         ready,
    output logic         frame_err,
    output logic         overrun
);

    localparam int unsigned DIV = F / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   idx_q;
    logic [N-1:0]    shift_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            deliver_q;
    logic [N-1:0]    data_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic rxs;
    assign rxs = sync2_q;

    // NOTE: every register here is updated with <= so all reads in this block
    // see the pre-edge values, exactly as the flops behave in hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deliver_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            deliver_q   <= 1'b0;

            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            // A pending byte reloads the buffer if it is empty or being drained
            // this very cycle; otherwise it is dropped and flagged.
            if (deliver_q) begin
                if (!valid_q || ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            deliver_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    // Held-low line: stay here until it returns high so a
                    // break reports a single frame error.
                    if (rxs) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a timed serial transmitter model feeds rx,
// an expected-byte queue is filled per frame and a monitor drains it on handshakes.
`timescale 1ns/1ps
module tb_uart_rx;

    // A short bit period keeps the run small; DIV divides exactly.
    localparam int unsigned F      = 50_000_000;
    localparam int unsigned BAUD   = 1_250_000;
    localparam int unsigned N      = 8;
    localparam int unsigned DIV    = F / BAUD;
    localparam real         BIT_NS = 1.0e9 / BAUD;
    localparam real         CLK_NS = 1.0e9 / F;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic         ready;
    logic [N-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         overrun;

    uart_rx #(.F(F), .BAUD(BAUD), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #10 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_exp = 0;
    int ov_exp = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a one-entry receive buffer. A good frame is lost to
    // overrun only if the buffer still holds an unread byte and nobody reads.
    task automatic expect_frame(input logic [N-1:0] b);
        if (!ready && exp_q.size() != 0) ov_exp++;
        else exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [N-1:0] b, input real bit_ns, input logic stop_val);
        logic [N+1:0] bits;
        bits = {stop_val, b, 1'b0};
        for (int i = 0; i < N + 2; i++) begin
            rx = bits[i];
            #(bit_ns);
        end
        rx = 1'b1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 30 * DIV && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check({tag, " queue empty"}, exp_q.size(), 0);
        check({tag, " frame_err count"}, fe_cnt, fe_exp);
        check({tag, " overrun count"}, ov_cnt, ov_exp);
    endtask

    // Monitor: samples on the falling edge, counts pulse cycles, checks
    // handshakes against the queue and data stability while stalled.
    logic         hold_q = 1'b0;
    logic [N-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err || overrun) check("frame_err/overrun exclusive", {31'b0, frame_err & overrun}, 0);
            if (hold_q && valid) check("data stable while stalled", data, hold_data);
            hold_q    = valid && !ready;
            hold_data = data;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected byte: got %02h, expected none (t=%0t)", data, $time);
                end else begin
                    check("delivered byte", data, exp_q.pop_front());
                end
            end
        end else begin
            hold_q = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] b;
        logic         r;
        real          fac;

        rst   = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset data", data, 0);
        check("reset valid", valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);

        // Back-to-back frames, ready high.
        expect_frame(8'h55);
        send_frame(8'h55, BIT_NS, 1'b1);
        expect_frame(8'hA3);
        send_frame(8'hA3, BIT_NS, 1'b1);
        drain_and_check("back-to-back");

        // Stalled consumer: first byte kept, next two overrun.
        set_ready(1'b0);
        expect_frame(8'h31);
        send_frame(8'h31, BIT_NS, 1'b1);
        expect_frame(8'h32);
        send_frame(8'h32, BIT_NS, 1'b1);
        expect_frame(8'h33);
        send_frame(8'h33, BIT_NS, 1'b1);
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        check("stalled data", data, 8'h31);
        check("stalled valid", valid, 1);
        check("overrun pulses", ov_cnt, ov_exp);
        set_ready(1'b1);
        drain_and_check("overrun");

        // Short glitch on an idle line.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (DIV / 4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        @(negedge clk);
        check("glitch valid", valid, 0);
        drain_and_check("glitch");

        // Bad stop bit followed by a held-low break, then a clean frame.
        send_frame(8'h7E, BIT_NS, 1'b0);
        fe_exp++;
        rx = 1'b0;
        #(3.0 * BIT_NS);
        rx = 1'b1;
        #(2.0 * BIT_NS);
        expect_frame(8'h41);
        send_frame(8'h41, BIT_NS, 1'b1);
        drain_and_check("break");

        // Reset in the middle of bit 4 of 0xF0.
        b = 8'hF0;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = b[4];
        #(BIT_NS / 2.0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid-frame reset data", data, 0);
            check("mid-frame reset valid", valid, 0);
            check("mid-frame reset pulses", {30'b0, frame_err, overrun}, 0);
        end
        rx = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #(2.0 * BIT_NS);
        expect_frame(8'h0F);
        send_frame(8'h0F, BIT_NS, 1'b1);
        drain_and_check("reset");

        // Transmitter 3% fast and 3% slow.
        expect_frame(8'h00);
        send_frame(8'h00, BIT_NS / 1.03, 1'b1);
        #(BIT_NS);
        expect_frame(8'hFF);
        send_frame(8'hFF, BIT_NS / 0.97, 1'b1);
        drain_and_check("baud tolerance");

        // Random bytes, random consumer stalls, small random baud error and gaps.
        for (int k = 0; k < 30; k++) begin
            r = ($urandom_range(0, 3) != 0);
            set_ready(r);
            repeat (3) @(posedge clk);
            b   = N'($urandom);
            fac = 1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0;
            expect_frame(b);
            send_frame(b, BIT_NS / fac, 1'b1);
            #(real'($urandom_range(0, 80)) * CLK_NS);
        end
        set_ready(1'b1);
        drain_and_check("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-stream receiver, the consumer on the far end of the uart_tx serial line. It samples an asynchronous 8N1 UART line and recovers each byte. Each byte is presented on a valid/ready stream port with the same semantics as StreamBus (N = data width). Typical use: a loopback board test or a host-command input path, feeding a stage that converts ASCII back to numbers.

Parameters:
F, 50000000, clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = F/BAUD, integer-truncated (434 at defaults)
N, 8, data bits per frame, LSB first

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rx  input  1  serial line, idle high, asynchronous to clk
data  output  N  received byte
valid  output  1  data holds an unconsumed byte
ready  input  1  downstream accepts data when valid&&ready at rising clk
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while the output buffer was still full

Behaviour:
- Reset (rst low, async):
  - data=0, valid=0, frame_err=0, overrun=0.
  - FSM to IDLE, counters to 0, synchronizer flops to 1.
- Input conditioning: rx passes through a 2-flop synchronizer; call the output rxs. The FSM sees only rxs. Fixed 2-cycle input latency.
- Baud counter: counts 0..DIV-1. It is cleared on every state entry.
- FSM states:
  - IDLE: on rxs==0, go to START and clear the counter.
  - START: when the counter reaches DIV/2-1 (mid start bit), sample rxs.
    - rxs==1: glitch; return to IDLE, nothing reported.
    - rxs==0: go to DATA with bit index 0.
  - DATA: every DIV cycles, sample rxs into shift register bit [index], LSB first. After bit N-1, go to STOP.
  - STOP: after DIV cycles (mid stop bit), sample rxs.
    - rxs==1: frame good; deliver the byte (see below) and go to IDLE.
    - rxs==0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. A held-low line produces exactly one frame_err and no further frames.
- Delivery (1-entry output buffer), on the cycle after a good stop sample:
  - If valid==0: data<=shift, valid<=1.
  - If valid==1 and ready==1 on that same cycle: the handshake and the reload happen together. data<=shift, valid stays 1, no overrun.
  - If valid==1 and ready==0: the new byte is dropped, data is unchanged, and overrun pulses for 1 cycle.
- Handshake:
  - valid&&ready clears valid on the next edge unless a reload happens on the same cycle.
  - data is stable while valid==1 and ready==0.
  - valid never depends combinationally on ready.
- Latency: valid rises 1 cycle after the mid-stop-bit sample, i.e. about 2+DIV/2+(N+1)*DIV clk cycles after the rx falling edge.
- Resynchronization: a new start bit is accepted from IDLE on the first low rxs after stop-bit validation. Back-to-back frames with no idle gap are therefore supported.
- Reset mid-frame: the partial byte is lost, no error pulse is produced, and reception restarts from IDLE with the synchronizer reset to idle-high.
- frame_err and overrun are never asserted together. Neither is sticky.

Test Plan:
1. Defaults (DIV=434), ready=1. Send 0x55, then 0xA3 with 1 stop bit and no gap → valid pulses twice with data=0x55 then 0xA3. frame_err=0, overrun=0.
2. ready=0. Send 0x31, 0x32, 0x33 → data stays 0x31 with valid held high. overrun pulses twice, 1 cycle each. Raising ready then yields 0x31 only.
3. 100-cycle low glitch on idle rx (shorter than 217) → no state leaves IDLE permanently; valid, frame_err and overrun all stay 0.
4. Frame 0x7E with stop bit forced low, line held low for 3 bit times, then high, then a clean 0x41 → exactly one frame_err pulse and 0x7E not delivered. 0x41 is received correctly.
5. Assert rst low in the middle of bit 4 of 0xF0, release, then send 0x0F → outputs 0 during reset; only 0x0F is delivered.
6. Baud tolerance: transmitter running at ±3% of 115200 sending 0x00 and 0xFF → both bytes received correctly with no frame_err.
